// File: rtl/dmem_access_stage.sv
// dmem_access_stage: MIPS data-memory stage, word RAM with wait states.
// Optional alignment faults enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_access_stage #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] read_data,
  output logic        misalign
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WC = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic          uns;
    logic [1:0]    size;
    logic [1:0]    off;
    logic [AW-1:0] idx;
    logic [31:0]   wdata;
  } op_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic          busy_q;
  logic          done_q;
  logic          mis_q;
  logic [31:0]   rdata_q;
  logic [31:0]   rdata_d;
  op_t           op_q;
  op_t           op_in;
  op_t           op_cur;
  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          is_half;
  logic          is_word;
  logic          fault_i;
  logic          accept;
  logic          fire;
  logic [1:0]    off_i;
  logic [3:0]    be;
  logic [31:0]   wlane;
  logic [31:0]   word_rd;
  logic [31:0]   shifted;
  logic          unused_addr;

  assign is_half = (size == 2'b01);
  assign is_word = size[1];
  assign accept  = (state_q == S_IDLE) & req
                 & (mem_read | mem_write);

`ifdef DMEM_ALIGN_CHECK_EN
  assign fault_i = (is_half & address[0])
                 | (is_word & (|address[1:0]));
  assign off_i   = address[1:0];
`else
  // Without fault detection, round down to natural alignment.
  assign fault_i = 1'b0;
  assign off_i   = is_word ? 2'b00 :
                   is_half ? {address[1], 1'b0} :
                             address[1:0];
`endif

  assign unused_addr = ^address[31:AW+2];

  always_comb begin
    op_in       = '0;
    op_in.rd    = mem_read;
    op_in.wr    = mem_write;
    op_in.uns   = load_unsigned;
    op_in.size  = size;
    op_in.off   = off_i;
    op_in.idx   = address[AW+1:2];
    op_in.wdata = write_data;
  end

  // With zero wait states the access uses the live inputs.
  assign op_cur = (state_q == S_IDLE) ? op_in : op_q;

  assign fire = ((state_q == S_WAIT) && (cnt_q == 4'd0))
              || (accept && !fault_i && (WC == 4'd0));

  always_comb begin
    be    = 4'b1111;
    wlane = op_cur.wdata;
    unique case (1'b1)
      (op_cur.size == 2'b00): begin
        be    = 4'b0001 << op_cur.off;
        wlane = {4{op_cur.wdata[7:0]}};
      end
      (op_cur.size == 2'b01): begin
        be    = op_cur.off[1] ? 4'b1100 : 4'b0011;
        wlane = {2{op_cur.wdata[15:0]}};
      end
      op_cur.size[1]: begin
        be    = 4'b1111;
        wlane = op_cur.wdata;
      end
    endcase
  end

  assign word_rd = mem_q[op_cur.idx];
  assign shifted = word_rd >> {op_cur.off, 3'b000};

  always_comb begin
    rdata_d = word_rd;
    unique case (1'b1)
      (op_cur.size == 2'b00):
        rdata_d = {{24{~op_cur.uns & shifted[7]}},
                   shifted[7:0]};
      (op_cur.size == 2'b01):
        rdata_d = {{16{~op_cur.uns & shifted[15]}},
                   shifted[15:0]};
      op_cur.size[1]:
        rdata_d = word_rd;
    endcase
    if (op_cur.wr) rdata_d = '0;
  end

  // Reset on the access edge discards the write.
  always_ff @(posedge clk) begin
    if (!reset && fire && op_cur.wr) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[op_cur.idx][8*i +: 8] <= wlane[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
      op_q    <= '0;
    end else begin
      done_q <= 1'b0;
      mis_q  <= 1'b0;
      if (fire && op_cur.rd) rdata_q <= rdata_d;
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            op_q   <= op_in;
            busy_q <= 1'b1;
            if (fault_i) begin
              state_q <= S_RESP;
              done_q  <= 1'b1;
              mis_q   <= 1'b1;
            end else if (WC == 4'd0) begin
              state_q <= S_RESP;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= WC - 4'd1;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_RESP;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign misalign  = mis_q;
  assign read_data = rdata_q;

endmodule

// File: tb/tb_dmem_access_stage.sv
// tb_dmem_access_stage: randomized and directed bench with a
// byte-addressed reference memory model.
module tb_dmem_access_stage;
  localparam int W = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [1:0]  size = 2'b00;
  logic        load_unsigned = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic        busy;
  logic        done;
  logic [31:0] read_data;
  logic        misalign;

  int errors = 0;
  int checks = 0;

  logic [7:0]  ref_mem [1024];
  logic [31:0] exp_rdata = '0;

  dmem_access_stage #(
    .DEPTH_WORDS(256),
    .WAIT_CYCLES(W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .mem_read(mem_read),
    .mem_write(mem_write),
    .size(size),
    .load_unsigned(load_unsigned),
    .address(address),
    .write_data(write_data),
    .busy(busy),
    .done(done),
    .read_data(read_data),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] sz);
    if (sz == 2'b00) return 1;
    if (sz == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit m_fault(input logic [1:0] sz,
                                 input logic [31:0] a);
`ifdef DMEM_ALIGN_CHECK_EN
    return (a % nbytes(sz)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int m_base(input logic [1:0] sz,
                                input logic [31:0] a);
    int b;
    b = int'(a % 1024);
    b = b - (b % nbytes(sz));
    return b;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz,
                                         input logic uns,
                                         input logic [31:0] a);
    int n;
    int b;
    logic [31:0] v;
    n = nbytes(sz);
    b = m_base(sz, a);
    v = '0;
    for (int i = 0; i < n; i++)
      v = v | (32'(ref_mem[b+i]) << (8*i));
    if (n < 4 && !uns && v[8*n-1])
      v = v | ~((32'd1 << (8*n)) - 32'd1);
    return v;
  endfunction

  task automatic m_op(input logic rd, input logic wr,
                      input logic [1:0] sz, input logic uns,
                      input logic [31:0] a, input logic [31:0] wd,
                      output int elat, output logic emis);
    int b;
    elat = 0;
    emis = 1'b0;
    if (!rd && !wr) return;
    if (m_fault(sz, a)) begin
      elat = 1;
      emis = 1'b1;
      return;
    end
    elat = W + 1;
    b = m_base(sz, a);
    if (wr) begin
      for (int i = 0; i < nbytes(sz); i++)
        ref_mem[b+i] = wd[8*i +: 8];
    end
    if (rd) exp_rdata = wr ? 32'h0 : m_load(sz, uns, a);
  endtask

  // ---------------- driver ----------------
  task automatic do_acc(input logic rd, input logic wr,
                        input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit exp_act,
                        output int lat, output bit bok,
                        output logic mis, output bit stray);
    @(negedge clk);
    bok = (busy === 1'b0);
    req = 1'b1;
    mem_read = rd;
    mem_write = wr;
    size = sz;
    load_unsigned = uns;
    address = a;
    write_data = wd;
    @(negedge clk);
    req = 1'b0;
    mem_read = 1'($urandom);
    mem_write = 1'($urandom);
    size = 2'($urandom);
    address = $urandom;
    write_data = $urandom;
    lat = 0;
    mis = 1'b0;
    stray = 1'b0;
    for (int n = 1; n <= 8 && lat == 0; n++) begin
      if (misalign === 1'b1 && done !== 1'b1) stray = 1'b1;
      if (exp_act && busy !== 1'b1) bok = 1'b0;
      if (!exp_act && busy !== 1'b0) bok = 1'b0;
      if (done === 1'b1) begin
        lat = n;
        mis = misalign;
      end else if (n < 8) begin
        @(negedge clk);
      end
    end
  endtask

  task automatic run(input logic rd, input logic wr,
                     input logic [1:0] sz, input logic uns,
                     input logic [31:0] a, input logic [31:0] wd,
                     output int lat, output int elat,
                     output bit bok, output logic mis,
                     output logic emis, output bit stray);
    m_op(rd, wr, sz, uns, a, wd, elat, emis);
    do_acc(rd, wr, sz, uns, a, wd, elat != 0,
           lat, bok, mis, stray);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    req = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b expected 0", done);
    end
    checks++;
    if (misalign !== 1'b0) begin
      errors++;
      $display("FAIL reset_misalign: got %b expected 0", misalign);
    end
    checks++;
    if (read_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h expected 0", read_data);
    end
    reset = 1'b0;
    exp_rdata = '0;
  endtask

  task automatic test_word();
    int lat, elat;
    bit bok, stray;
    logic mis, emis;
    run(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF,
        lat, elat, bok, mis, emis, stray);
    checks++;
    if (lat !== W + 1) begin
      errors++;
      $display("FAIL sw_latency: got %0d expected %0d", lat, W + 1);
    end
    checks++;
    if (!bok) begin
      errors++;
      $display("FAIL sw_busy: got bad expected busy T+1..done");
    end
    checks++;
    if (read_data !== 32'h0) begin
      errors++;
      $display("FAIL sw_rdata_hold: got %h expected 0", read_data);
    end
    run(1, 0, 2'b10, 0, 32'h10, 32'h0,
        lat, elat, bok, mis, emis, stray);
    checks++;
    if (lat !== W + 1) begin
      errors++;
      $display("FAIL lw_latency: got %0d expected %0d", lat, W + 1);
    end
    checks++;
    if (read_data !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL lw_data: got %h expected deadbeef", read_data);
    end
  endtask

  task automatic test_lanes();
    int lat, elat;
    bit bok, stray;
    logic mis, emis;
    run(0, 1, 2'b00, 0, 32'h11, 32'hAAAAAA80,
        lat, elat, bok, mis, emis, stray);
    run(1, 0, 2'b00, 0, 32'h11, 32'h0,
        lat, elat, bok, mis, emis, stray);
    checks++;
    if (read_data !== 32'hFFFFFF80) begin
      errors++;
      $display("FAIL lb: got %h expected ffffff80", read_data);
    end
    run(1, 0, 2'b00, 1, 32'h11, 32'h0,
        lat, elat, bok, mis, emis, stray);
    checks++;
    if (read_data !== 32'h00000080) begin
      errors++;
      $display("FAIL lbu: got %h expected 00000080", read_data);
    end
    run(1, 0, 2'b10, 0, 32'h10, 32'h0,
        lat, elat, bok, mis, emis, stray);
    checks++;
    if (read_data !== 32'hDEAD80EF) begin
      errors++;
      $display("FAIL lw_merged: got %h expected dead80ef", read_data);
    end
    run(1, 0, 2'b01, 0, 32'h12, 32'h0,
        lat, elat, bok, mis, emis, stray);
    checks++;
    if (read_data !== 32'hFFFFDEAD) begin
      errors++;
      $display("FAIL lh: got %h expected ffffdead", read_data);
    end
  endtask

  task automatic test_misalign();
    int lat, elat;
    bit bok, stray;
    logic mis, emis;
    run(1, 0, 2'b01, 0, 32'h13, 32'h0,
        lat, elat, bok, mis, emis, stray);
    checks++;
    if (lat !== elat) begin
      errors++;
      $display("FAIL lh13_latency: got %0d expected %0d", lat, elat);
    end
    checks++;
    if (mis !== emis) begin
      errors++;
      $display("FAIL lh13_misalign: got %b expected %b", mis, emis);
    end
    checks++;
    if (read_data !== 32'hFFFFDEAD) begin
      errors++;
      $display("FAIL lh13_rdata: got %h expected ffffdead", read_data);
    end
    checks++;
    if (stray || !bok) begin
      errors++;
      $display("FAIL lh13_handshake: got stray=%0d bok=%0d expected 0/1",
               stray, bok);
    end
    run(0, 1, 2'b10, 0, 32'h12, 32'h12345678,
        lat, elat, bok, mis, emis, stray);
    checks++;
    if (lat !== elat || mis !== emis) begin
      errors++;
      $display("FAIL sw12: got lat=%0d mis=%b expected lat=%0d mis=%b",
               lat, mis, elat, emis);
    end
    run(1, 0, 2'b10, 0, 32'h10, 32'h0,
        lat, elat, bok, mis, emis, stray);
    checks++;
    if (read_data !== exp_rdata) begin
      errors++;
      $display("FAIL sw12_mem: got %h expected %h", read_data, exp_rdata);
    end
`ifdef DMEM_ALIGN_CHECK_EN
    checks++;
    if (read_data !== 32'hDEAD80EF) begin
      errors++;
      $display("FAIL sw12_unchanged: got %h expected dead80ef",
               read_data);
    end
`endif
  endtask

  task automatic test_busy();
    int lat, elat, n_done;
    bit bok, stray;
    logic mis, emis;
    n_done = 0;
    run(0, 1, 2'b10, 0, 32'h28, 32'h0BADC0DE,
        lat, elat, bok, mis, emis, stray);
    m_op(0, 1, 2'b10, 0, 32'h24, 32'h5555AAAA, elat, emis);
    @(negedge clk);
    req = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b1;
    size = 2'b10;
    address = 32'h24;
    write_data = 32'h5555AAAA;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c <= W + 1) begin
        req = 1'b1;
        mem_write = 1'b1;
        address = 32'h28;
        write_data = 32'h11111111;
      end else begin
        req = 1'b0;
      end
      if (done === 1'b1) n_done++;
    end
    checks++;
    if (n_done !== 1) begin
      errors++;
      $display("FAIL busy_one_done: got %0d expected 1", n_done);
    end
    run(1, 0, 2'b10, 0, 32'h28, 32'h0,
        lat, elat, bok, mis, emis, stray);
    checks++;
    if (read_data !== 32'h0BADC0DE) begin
      errors++;
      $display("FAIL busy_ignored: got %h expected 0badc0de", read_data);
    end
    run(1, 0, 2'b10, 0, 32'h24, 32'h0,
        lat, elat, bok, mis, emis, stray);
    checks++;
    if (read_data !== 32'h5555AAAA) begin
      errors++;
      $display("FAIL busy_first: got %h expected 5555aaaa", read_data);
    end
  endtask

  task automatic test_reset_abort();
    int lat, elat, n_done;
    bit bok, stray;
    logic mis, emis;
    n_done = 0;
    @(negedge clk);
    req = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b1;
    size = 2'b10;
    address = 32'h10;
    write_data = 32'h0;
    @(negedge clk);
    req = 1'b0;
    if (done === 1'b1) n_done++;
    @(negedge clk);
    reset = 1'b1;
    if (done === 1'b1) n_done++;
    @(negedge clk);
    reset = 1'b0;
    if (done === 1'b1) n_done++;
    exp_rdata = '0;
    checks++;
    if (busy !== 1'b0 || read_data !== 32'h0) begin
      errors++;
      $display("FAIL abort_state: got busy=%b rdata=%h expected 0/0",
               busy, read_data);
    end
    repeat (5) begin
      @(negedge clk);
      if (done === 1'b1) n_done++;
    end
    checks++;
    if (n_done !== 0) begin
      errors++;
      $display("FAIL abort_done: got %0d expected 0", n_done);
    end
    run(1, 0, 2'b10, 0, 32'h10, 32'h0,
        lat, elat, bok, mis, emis, stray);
    checks++;
    if (read_data !== exp_rdata) begin
      errors++;
      $display("FAIL abort_mem: got %h expected %h", read_data, exp_rdata);
    end
`ifdef DMEM_ALIGN_CHECK_EN
    checks++;
    if (read_data !== 32'hDEAD80EF) begin
      errors++;
      $display("FAIL abort_mem_lit: got %h expected dead80ef", read_data);
    end
`endif
  endtask

  task automatic test_wrap();
    int lat, elat;
    bit bok, stray;
    logic mis, emis;
    run(0, 1, 2'b10, 0, 32'h400, 32'hCAFEF00D,
        lat, elat, bok, mis, emis, stray);
    run(1, 0, 2'b10, 0, 32'h000, 32'h0,
        lat, elat, bok, mis, emis, stray);
    checks++;
    if (read_data !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL wrap: got %h expected cafef00d", read_data);
    end
  endtask

  task automatic test_random();
    int lat, elat;
    bit bok, stray;
    logic mis, emis;
    logic rd, wr, uns;
    logic [1:0] sz;
    logic [31:0] a, wd;
    int sel;
    for (int k = 0; k < 64; k++)
      run(0, 1, 2'b10, 0, 32'h200 + 32'(4*k), $urandom,
          lat, elat, bok, mis, emis, stray);
    for (int k = 0; k < 150; k++) begin
      sel = $urandom_range(0, 7);
      rd = (sel == 1) || (sel >= 2 && sel <= 4);
      wr = (sel == 1) || (sel >= 5);
      sz = 2'($urandom);
      uns = 1'($urandom);
      a = ($urandom & 32'hFFFFFC00)
        | (32'h200 + 32'($urandom_range(0, 255)));
      wd = $urandom;
      run(rd, wr, sz, uns, a, wd, lat, elat, bok, mis, emis, stray);
      checks++;
      if (lat !== elat) begin
        errors++;
        $display("FAIL rnd_latency[%0d]: got %0d expected %0d",
                 k, lat, elat);
      end
      checks++;
      if (mis !== emis || stray) begin
        errors++;
        $display("FAIL rnd_misalign[%0d]: got %b stray=%0d expected %b",
                 k, mis, stray, emis);
      end
      checks++;
      if (!bok) begin
        errors++;
        $display("FAIL rnd_busy[%0d]: got bad expected clean busy", k);
      end
      checks++;
      if (read_data !== exp_rdata) begin
        errors++;
        $display("FAIL rnd_rdata[%0d]: got %h expected %h a=%h sz=%0d",
                 k, read_data, exp_rdata, a, sz);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    test_reset();
    test_word();
    test_lanes();
    test_misalign();
    test_busy();
    test_reset_abort();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_access_stage.md
# dmem_access_stage

Memory-access stage of the MIPS datapath, directly downstream of the 32-bit ALU. It consumes the ALU result as an effective address and the rt register content as store data. It performs byte, halfword and word loads and stores on an internal word-organised data RAM, adding a programmable number of wait states. Completion is reported through a busy/done handshake to the control unit, and load results go to the write-back path.

## Interface
- DEPTH_WORDS, 256: RAM depth in 32-bit words; power of two, 16..4096.
- WAIT_CYCLES, 1: extra wait states per access; range 0..15.

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req  input  1  access request; sampled only when busy=0
- mem_read  input  1  load request
- mem_write  input  1  store request
- size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word
- load_unsigned  input  1  zero-extend (1) or sign-extend (0) byte/half loads
- address  input  32  effective address (ALU result)
- write_data  input  32  store data (rt content); low byte/half used for SB/SH
- busy  output  1  access in progress; new req ignored
- done  output  1  one-cycle completion pulse
- read_data  output  32  load result; valid when done=1 on a load
- misalign  output  1  alignment fault; valid only with done

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE, req=1, mem_read|mem_write=1, aligned:**
  - Latch all inputs.
  - Load the wait counter with WAIT_CYCLES.
  - Go to WAIT, or perform the access immediately when WAIT_CYCLES=0.
- **WAIT:** decrement the counter. At the edge where the counter is 0, perform the access and go to RESP.
- **RESP:** done=1 for exactly one cycle, then return to IDLE.
- req with mem_read=mem_write=0: ignored, no done.
- mem_read=mem_write=1: store performed; read_data forced to 0 on that done.
- **Indexing and wrap:**
  - Word index is address[log2(DEPTH_WORDS)+1:2].
  - Higher address bits are ignored, so addresses wrap modulo 4*DEPTH_WORDS bytes.
- **Byte lanes (little-endian):**
  - address[1:0]=0 maps to bits 7:0.
  - SB writes a single lane; SH writes lanes {1,0} or {3,2}; other lanes are untouched.
- **Loads:**
  - The selected byte or half is right-justified, then sign- or zero-extended per load_unsigned.
  - load_unsigned is ignored for word loads.
- **read_data:**
  - Updated only on load completion.
  - Holds its value across stores and idle cycles.
- Alignment fault: halfword with address[0]=1, or word with address[1:0]≠0 (see Configuration).
  - Faulting request: no RAM access and no wait states.
  - done=1 and misalign=1 in the cycle after acceptance.
  - read_data is unchanged.
- **Reset:**
  - busy=0, done=0, misalign=0, read_data=0; FSM goes to IDLE; counter=0.
  - RAM contents are not cleared.
  - Reset asserted in WAIT or RESP aborts the access. If reset coincides with the access edge, reset wins and the write is discarded.

## Timing
- Request accepted in cycle T (busy=0, req=1).
- busy=1 from cycle T+1 through the done cycle inclusive; 0 otherwise.
- Aligned access: RAM updated or read at the end of cycle T+WAIT_CYCLES; done=1 in cycle T+WAIT_CYCLES+1.
- Latency is WAIT_CYCLES+1. The earliest next acceptance is cycle T+WAIT_CYCLES+2.
- Misaligned access: done=1 and misalign=1 in cycle T+1; next acceptance at T+2.
- misalign is 0 whenever done=0.
- Inputs need only be valid in the acceptance cycle; later changes have no effect.

## Configuration
- DMEM_ALIGN_CHECK_EN
  - Defined: alignment faults are detected as described in Operation.
  - Undefined: misalign is tied to 0. Low address bits are forced to natural alignment (address[0] ignored for halfwords, address[1:0] ignored for words) and the access proceeds with normal latency.

## Test plan
All scenarios use WAIT_CYCLES=2 and DEPTH_WORDS=256, with the macro defined unless stated.
- **Reset:** hold reset 2 cycles → busy=0, done=0, misalign=0, read_data=0x00000000.
- **Word store/load:**
  - SW 0xDEADBEEF @0x10 accepted at T → done at T+3, busy T+1..T+3.
  - Then LW @0x10 → done at T'+3 with read_data=0xDEADBEEF.
- **Byte/half lanes:**
  - After the word store above, SB 0x80 @0x11; then LB @0x11 → 0xFFFFFF80.
  - LBU @0x11 → 0x00000080.
  - LW @0x10 → 0xDEAD80EF.
  - LH @0x12 → 0xFFFFDEAD.
- **Misalignment:**
  - LH @0x13 → done and misalign=1 at T+1; read_data unchanged.
  - SW 0x12345678 @0x12 → memory unchanged.
  - Macro undefined: LH @0x13 reads the half at 0x12 (0xFFFFDEAD), misalign=0.
- **Busy and reset:**
  - req asserted during busy → ignored, exactly one done.
  - Reset asserted at T+2 of SW 0x0 @0x10 → done never pulses; later LW @0x10 still returns 0xDEAD80EF.
- **Wrap:** SW 0xCAFEF00D @0x400 → LW @0x000 returns 0xCAFEF00D.
